// File: rtl/oh_tbus_arbiter.sv
// Round-robin arbiter for a shared tristate bus: one-hot grant/oe with a fixed all-off turnaround gap.
// Define OH_TBUS_PARK_EN to keep the last owner's driver enabled (bus parked) while nobody requests.
module oh_tbus_arbiter #(
   parameter int N       = 4,
   parameter int TURN    = 1,
   parameter int MAXHOLD = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic [N-1:0]         oe,
   output logic                 busy,
   output logic [$clog2(N)-1:0] owner_id
);

   localparam int IDW = $clog2(N);
   localparam int TW  = (TURN > 1) ? $clog2(TURN + 1) : 1;
   localparam int HW  = (MAXHOLD > 1) ? $clog2(MAXHOLD + 1) : 1;
   localparam bit HOLD_EN = (MAXHOLD > 0);
   localparam logic [TW-1:0]  TURN_LAST = TW'(TURN);
   localparam logic [HW-1:0]  HOLD_LAST = HW'(MAXHOLD);
   localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);
   localparam logic [N-1:0]   ONE       = N'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_TURN
`ifdef OH_TBUS_PARK_EN
      , ST_PARK
`endif
   } state_t;

   state_t         state, state_nx;
   logic [N-1:0]   grant_nx, oe_nx;
   logic [IDW-1:0] owner_nx, ptr, ptr_nx, win;
   logic [HW-1:0]  hold_cnt, hold_nx;
   logic [TW-1:0]  turn_cnt, turn_nx;

   // Rotate the requests so the pointer sits at bit 0, then take the lowest set bit.
   function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
      logic [2*N-1:0] rot;
      int w;
      w = 0;
      rr_pick = p;
      rot = {r, r} >> p;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            w = (int'(p) + i) % N;
            rr_pick = w[IDW-1:0];
         end
      end
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         grant    <= '0;
         oe       <= '0;
         busy     <= 1'b0;
         owner_id <= '0;
         ptr      <= '0;
         hold_cnt <= '0;
         turn_cnt <= '0;
      end else begin
         state    <= state_nx;
         grant    <= grant_nx;
         oe       <= oe_nx;
         busy     <= |oe_nx;
         owner_id <= owner_nx;
         ptr      <= ptr_nx;
         hold_cnt <= hold_nx;
         turn_cnt <= turn_nx;
      end
   end

   always_comb begin
      state_nx = state;
      grant_nx = grant;
      oe_nx    = oe;
      owner_nx = owner_id;
      ptr_nx   = ptr;
      hold_nx  = hold_cnt;
      turn_nx  = turn_cnt;
      win      = rr_pick(req, ptr);

      case (state)
         ST_IDLE: begin
            if (|req) begin
               state_nx = ST_DRIVE;
               grant_nx = ONE << win;
               oe_nx    = ONE << win;
               owner_nx = win;
               hold_nx  = HW'(1);
            end
         end

         // Only the owner dropping its request or the hold limit ends a tenure.
         ST_DRIVE: begin
            if (!req[owner_id] || (HOLD_EN && hold_cnt == HOLD_LAST)) begin
               grant_nx = '0;
               ptr_nx   = (owner_id == LAST_ID) ? '0 : owner_id + IDW'(1);
`ifdef OH_TBUS_PARK_EN
               if ((req & ~grant) == '0) begin
                  state_nx = ST_PARK;
               end else begin
                  oe_nx    = '0;
                  state_nx = ST_TURN;
                  turn_nx  = TW'(1);
               end
`else
               oe_nx    = '0;
               state_nx = ST_TURN;
               turn_nx  = TW'(1);
`endif
            end else begin
               hold_nx = hold_cnt + HW'(1);
            end
         end

         ST_TURN: begin
            if (turn_cnt == TURN_LAST) begin
               turn_nx = '0;
               if (|req) begin
                  state_nx = ST_DRIVE;
                  grant_nx = ONE << win;
                  oe_nx    = ONE << win;
                  owner_nx = win;
                  hold_nx  = HW'(1);
               end else begin
                  state_nx = ST_IDLE;
               end
            end else begin
               turn_nx = turn_cnt + TW'(1);
            end
         end

`ifdef OH_TBUS_PARK_EN
         // The parked driver may resume instantly; anyone else must wait out the gap.
         ST_PARK: begin
            if ((req & ~oe) != '0) begin
               oe_nx    = '0;
               state_nx = ST_TURN;
               turn_nx  = TW'(1);
            end else if (req[owner_id]) begin
               state_nx = ST_DRIVE;
               grant_nx = oe;
               hold_nx  = HW'(1);
            end
         end
`endif

         default: begin
            state_nx = ST_IDLE;
            grant_nx = '0;
            oe_nx    = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_oh_tbus_arbiter.sv
// Randomized self-checking bench for oh_tbus_arbiter (default build, no parking) against a
// tenure/gap reference model.
module tb_oh_tbus_arbiter;

   localparam int N       = 4;
   localparam int TURN    = 2;
   localparam int MAXHOLD = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] req;
   logic [N-1:0] grant;
   logic [N-1:0] oe;
   logic         busy;
   logic [1:0]   owner_id;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the bus, how long they have held it, how much gap remains.
   bit m_drive;
   int m_owner;
   int m_held;
   int m_gap;
   int m_ptr;
   int m_last;

   oh_tbus_arbiter #(.N(N), .TURN(TURN), .MAXHOLD(MAXHOLD)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .grant    (grant),
      .oe       (oe),
      .busy     (busy),
      .owner_id (owner_id)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic modelGrant(input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (!m_drive && r[i]) begin
            m_drive = 1'b1;
            m_owner = i;
            m_last  = i;
            m_held  = 1;
         end
      end
   endtask

   task automatic modelStep(input bit rst, input logic [N-1:0] r);
      if (rst) begin
         m_drive = 1'b0;
         m_owner = 0;
         m_held  = 0;
         m_gap   = 0;
         m_ptr   = 0;
         m_last  = 0;
      end else if (m_drive) begin
         if (!r[m_owner] || m_held == MAXHOLD) begin
            m_drive = 1'b0;
            m_ptr   = (m_owner + 1) % N;
            m_gap   = TURN;
         end else begin
            m_held++;
         end
      end else if (m_gap > 1) begin
         m_gap--;
      end else begin
         m_gap = 0;
         modelGrant(r);
      end
   endtask

   task automatic applyStimulus(input bit rst, input logic [N-1:0] r);
      logic [N-1:0] exp_vec;
      reset = rst;
      req   = r;
      @(posedge clk);
      modelStep(rst, r);
      @(negedge clk);
      exp_vec = m_drive ? (N'(1) << m_owner) : '0;
      checkOutput("grant", 32'(grant), 32'(exp_vec));
      checkOutput("oe", 32'(oe), 32'(exp_vec));
      checkOutput("busy", 32'(busy), 32'(m_drive));
      checkOutput("owner_id", 32'(owner_id), 32'(m_last));
      checkOutput("oe_onehot", 32'($countones(oe) <= 1), 32'd1);
   endtask

   initial begin
      int hi;
      logic [N-1:0] r;
      reset = 1'b1;
      req   = '0;
      modelStep(1'b1, '0);

      applyStimulus(1'b1, 4'b0001);
      applyStimulus(1'b1, 4'b0001);
      checkOutput("rst_grant", 32'(grant), 32'd0);
      checkOutput("rst_owner", 32'(owner_id), 32'd0);

      applyStimulus(1'b0, 4'b0001);
      checkOutput("first_grant", 32'(grant), 32'h1);
      checkOutput("first_busy", 32'(busy), 32'd1);

      repeat (3) applyStimulus(1'b0, 4'b0101);
      applyStimulus(1'b0, 4'b0100);
      checkOutput("release_oe", 32'(oe), 32'd0);
      applyStimulus(1'b0, 4'b0100);
      checkOutput("gap_oe", 32'(oe), 32'd0);
      applyStimulus(1'b0, 4'b0100);
      checkOutput("handover_oe", 32'(oe), 32'h4);
      checkOutput("handover_owner", 32'(owner_id), 32'd2);

      applyStimulus(1'b1, 4'b0100);
      checkOutput("midreset_oe", 32'(oe), 32'd0);
      checkOutput("midreset_owner", 32'(owner_id), 32'd0);
      applyStimulus(1'b0, 4'b1000);
      checkOutput("post_reset_grant", 32'(grant), 32'h8);

      repeat (45) applyStimulus(1'b0, 4'b1111);

      applyStimulus(1'b1, 4'b0000);
      hi = 0;
      for (int c = 0; c < 20; c++) begin
         applyStimulus(1'b0, 4'b0010);
         if (oe == 4'b0010) hi++;
      end
      checkOutput("maxhold_hi_cycles", 32'(hi), 32'd16);

      r = '0;
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(0, 5) == 0) r = N'($urandom_range(0, 15));
         applyStimulus($urandom_range(0, 79) == 0, r);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
